// File: rtl/alu_pkg.sv
// Shared types for the ALU issue controller: widths, FSM state and the command bundle.
package alu_pkg;

  localparam int ALU_W      = 8;
  localparam int ALU_CTRL_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } alu_issue_state_t;

  typedef struct packed {
    logic                  ld;
    logic                  a_sel;
    logic [ALU_W-1:0]      a;
    logic [ALU_W-1:0]      b;
    logic [ALU_CTRL_W-1:0] control_line;
    logic                  mode_select;
    logic                  cin;
    logic                  use_carry;
    logic                  wb;
  } alu_cmd_t;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issue/accumulate controller in front of the 8-bit combinational ALU.
// Define ALU_ISSUE_CHAIN_EN to let a command take its carry-in from carry_flag.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter logic [ALU_W-1:0] ACC_RESET = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_ld,
  input  logic                  cmd_a_sel,
  input  logic [ALU_W-1:0]      cmd_a,
  input  logic [ALU_W-1:0]      cmd_b,
  input  logic [ALU_CTRL_W-1:0] cmd_control_line,
  input  logic                  cmd_mode_select,
  input  logic                  cmd_cin,
  input  logic                  cmd_use_carry,
  input  logic                  cmd_wb,
  output logic [ALU_W-1:0]      alu_a,
  output logic [ALU_W-1:0]      alu_b,
  output logic                  alu_c_in,
  output logic [ALU_CTRL_W-1:0] alu_control_line,
  output logic                  alu_mode_select,
  input  logic [ALU_W-1:0]      alu_out,
  input  logic                  alu_c_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ALU_W-1:0]      res_data,
  output logic                  res_carry,
  output logic [ALU_W-1:0]      acc,
  output logic                  carry_flag,
  output logic                  zero_flag
);

  alu_issue_state_t      state_q, state_d;
  alu_cmd_t              cmd;
  logic [ALU_W-1:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic                  alu_c_in_q, alu_c_in_d;
  logic [ALU_CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic                  alu_mode_q, alu_mode_d;
  logic                  ld_q, ld_d, wb_q, wb_d;
  logic [ALU_W-1:0]      res_data_q, res_data_d;
  logic                  res_carry_q, res_carry_d;
  logic [ALU_W-1:0]      acc_q, acc_d;
  logic                  carry_q, carry_d, zero_q, zero_d;
  logic                  c_in_sel;

  assign cmd = '{ld: cmd_ld, a_sel: cmd_a_sel, a: cmd_a, b: cmd_b,
                 control_line: cmd_control_line, mode_select: cmd_mode_select,
                 cin: cmd_cin, use_carry: cmd_use_carry, wb: cmd_wb};

`ifdef ALU_ISSUE_CHAIN_EN
  assign c_in_sel = cmd.use_carry ? carry_q : cmd.cin;
`else
  logic unused_use_carry;
  assign unused_use_carry = cmd.use_carry;
  assign c_in_sel         = cmd.cin;
`endif

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_c_in_d  = alu_c_in_q;
    alu_ctrl_d  = alu_ctrl_q;
    alu_mode_d  = alu_mode_q;
    ld_d        = ld_q;
    wb_d        = wb_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d    = EXEC;
          alu_a_d    = cmd.a_sel ? cmd.a : acc_q;
          alu_b_d    = cmd.b;
          alu_c_in_d = c_in_sel;
          alu_ctrl_d = cmd.control_line;
          alu_mode_d = cmd.mode_select;
          ld_d       = cmd.ld;
          wb_d       = cmd.wb;
        end
      end
      EXEC: begin
        state_d = DONE;
        // A load reuses the registered B operand as its data; the ALU result is ignored.
        if (ld_q) begin
          res_data_d  = alu_b_q;
          res_carry_d = 1'b0;
          acc_d       = alu_b_q;
          zero_d      = (alu_b_q == '0);
        end else begin
          res_data_d  = alu_out;
          res_carry_d = alu_c_out;
          if (wb_q) begin
            acc_d   = alu_out;
            carry_d = alu_c_out;
            zero_d  = (alu_out == '0);
          end
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_c_in_q  <= 1'b0;
      alu_ctrl_q  <= '0;
      alu_mode_q  <= 1'b0;
      ld_q        <= 1'b0;
      wb_q        <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      acc_q       <= ACC_RESET;
      carry_q     <= 1'b0;
      zero_q      <= (ACC_RESET == '0);
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_c_in_q  <= alu_c_in_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_mode_q  <= alu_mode_d;
      ld_q        <= ld_d;
      wb_q        <= wb_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
    end
  end

  // Ready is masked by reset so nothing is offered while the block is held.
  assign cmd_ready        = rst_n && (state_q == IDLE);
  assign res_valid        = (state_q == DONE);
  assign alu_a            = alu_a_q;
  assign alu_b            = alu_b_q;
  assign alu_c_in         = alu_c_in_q;
  assign alu_control_line = alu_ctrl_q;
  assign alu_mode_select  = alu_mode_q;
  assign res_data         = res_data_q;
  assign res_carry        = res_carry_q;
  assign acc              = acc_q;
  assign carry_flag       = carry_q;
  assign zero_flag        = zero_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with an adder ALU stub and an accumulator reference model.
// Honours ALU_ISSUE_CHAIN_EN the same way the design does.
module tb_alu_issue_ctrl;

  localparam logic [7:0] ACC_RST = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic       cmd_ld = 1'b0, cmd_a_sel = 1'b0;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic [2:0] cmd_control_line = '0;
  logic       cmd_mode_select = 1'b0, cmd_cin = 1'b0, cmd_use_carry = 1'b0, cmd_wb = 1'b0;
  logic [7:0] alu_a, alu_b, alu_out;
  logic       alu_c_in, alu_mode_select, alu_c_out;
  logic [2:0] alu_control_line;
  logic       res_valid, res_ready = 1'b0, res_carry;
  logic [7:0] res_data, acc;
  logic       carry_flag, zero_flag;

  int vectors = 0;
  int miscompares = 0;

  // reference state, updated from the behavioural rules only
  logic [7:0] m_acc;
  logic       m_carry, m_zero;
`ifdef ALU_ISSUE_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  always #5 clk = ~clk;

  // ALU stub: plain 9-bit add
  logic [8:0] alu_sum;
  assign alu_sum   = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_c_in};
  assign alu_out   = alu_sum[7:0];
  assign alu_c_out = alu_sum[8];

  alu_issue_ctrl #(.ACC_RESET(ACC_RST)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ld(cmd_ld), .cmd_a_sel(cmd_a_sel), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_control_line(cmd_control_line), .cmd_mode_select(cmd_mode_select),
    .cmd_cin(cmd_cin), .cmd_use_carry(cmd_use_carry), .cmd_wb(cmd_wb),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in),
    .alu_control_line(alu_control_line), .alu_mode_select(alu_mode_select),
    .alu_out(alu_out), .alu_c_out(alu_c_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry),
    .acc(acc), .carry_flag(carry_flag), .zero_flag(zero_flag)
  );

  task automatic check_output(input string tag, input logic [8:0] observed, input logic [8:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_state(input string tag);
    check_output({tag, "_acc"}, {1'b0, acc}, {1'b0, m_acc});
    check_output({tag, "_carry_flag"}, {8'd0, carry_flag}, {8'd0, m_carry});
    check_output({tag, "_zero_flag"}, {8'd0, zero_flag}, {8'd0, m_zero});
  endtask

  task automatic scramble_cmd();
    cmd_ld = 1'($urandom); cmd_a_sel = 1'($urandom);
    cmd_a = 8'($urandom); cmd_b = 8'($urandom);
    cmd_control_line = 3'($urandom); cmd_mode_select = 1'($urandom);
    cmd_cin = 1'($urandom); cmd_use_carry = 1'($urandom); cmd_wb = 1'($urandom);
  endtask

  // One full command: accept, EXEC, DONE held for wait_cycles, then released.
  task automatic apply_stimulus(input bit ld, input bit a_sel, input logic [7:0] a, input logic [7:0] b,
                                input logic [2:0] ctl, input bit mode, input bit cin, input bit use_carry,
                                input bit wb, input int wait_cycles, input bit keep_valid);
    logic [7:0] e_a, e_res;
    logic       e_cin, e_rc;
    logic [8:0] sum;
    @(negedge clk);
    check_output("cmd_ready_idle", {8'd0, cmd_ready}, 9'd1);
    cmd_valid = 1'b1; cmd_ld = ld; cmd_a_sel = a_sel; cmd_a = a; cmd_b = b;
    cmd_control_line = ctl; cmd_mode_select = mode; cmd_cin = cin;
    cmd_use_carry = use_carry; cmd_wb = wb;
    e_a   = a_sel ? a : m_acc;
    e_cin = (CHAIN && use_carry) ? m_carry : cin;
    sum   = 9'(e_a) + 9'(b) + 9'(e_cin);
    if (ld) begin
      e_res = b; e_rc = 1'b0;
    end else begin
      e_res = sum[7:0]; e_rc = sum[8];
    end
    @(posedge clk); #1;
    check_output("alu_a", {1'b0, alu_a}, {1'b0, e_a});
    check_output("alu_b", {1'b0, alu_b}, {1'b0, b});
    check_output("alu_c_in", {8'd0, alu_c_in}, {8'd0, e_cin});
    check_output("alu_control_line", {6'd0, alu_control_line}, {6'd0, ctl});
    check_output("alu_mode_select", {8'd0, alu_mode_select}, {8'd0, mode});
    check_output("res_valid_exec", {8'd0, res_valid}, 9'd0);
    check_output("cmd_ready_exec", {8'd0, cmd_ready}, 9'd0);
    @(negedge clk);
    if (keep_valid) scramble_cmd(); else cmd_valid = 1'b0;
    @(posedge clk); #1;
    if (ld) begin
      m_acc = b; m_zero = (b == 8'd0);
    end else if (wb) begin
      m_acc = e_res; m_carry = e_rc; m_zero = (e_res == 8'd0);
    end
    check_output("res_valid_done", {8'd0, res_valid}, 9'd1);
    check_output("res_data", {1'b0, res_data}, {1'b0, e_res});
    check_output("res_carry", {8'd0, res_carry}, {8'd0, e_rc});
    check_state("done");
    for (int i = 0; i < wait_cycles; i++) begin
      @(negedge clk);
      if (keep_valid) scramble_cmd();
      @(posedge clk); #1;
      check_output("hold_res_valid", {8'd0, res_valid}, 9'd1);
      check_output("hold_cmd_ready", {8'd0, cmd_ready}, 9'd0);
      check_output("hold_res_data", {1'b0, res_data}, {1'b0, e_res});
      check_output("hold_alu_a", {1'b0, alu_a}, {1'b0, e_a});
      check_state("hold");
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    check_output("release_res_valid", {8'd0, res_valid}, 9'd0);
    @(negedge clk);
    res_ready = 1'b0;
    cmd_valid = 1'b0;
  endtask

  initial begin
    m_acc = ACC_RST; m_carry = 1'b0; m_zero = (ACC_RST == 8'd0);

    // reset values while held and right after release
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_cmd_ready", {8'd0, cmd_ready}, 9'd0);
    check_output("rst_res_valid", {8'd0, res_valid}, 9'd0);
    check_output("rst_res_data", {1'b0, res_data}, 9'd0);
    check_output("rst_alu_a", {1'b0, alu_a}, 9'd0);
    check_output("rst_alu_c_in", {8'd0, alu_c_in}, 9'd0);
    check_state("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_output("post_rst_cmd_ready", {8'd0, cmd_ready}, 9'd1);
    check_output("post_rst_res_valid", {8'd0, res_valid}, 9'd0);

    $display("[TB] directed: load, add, overflow, chain");
    apply_stimulus(1, 0, 8'h00, 8'h02, 3'd0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 8'h00, 8'h03, 3'd1, 0, 0, 0, 1, 0, 0);
    apply_stimulus(0, 1, 8'hFF, 8'h01, 3'd2, 1, 0, 0, 1, 0, 0);
    apply_stimulus(0, 1, 8'h00, 8'h00, 3'd3, 0, 0, 1, 0, 0, 0);
    check_output("chain_res_data", {1'b0, res_data}, CHAIN ? 9'd1 : 9'd0);

    $display("[TB] DONE held with cmd_valid high");
    apply_stimulus(0, 1, 8'h10, 8'h20, 3'd4, 1, 1, 0, 1, 5, 1);
    repeat (2) begin
      @(posedge clk); #1;
      check_output("single_result", {8'd0, res_valid}, 9'd0);
    end

    $display("[TB] randomized commands");
    for (int n = 0; n < 40; n++) begin
      apply_stimulus(($urandom_range(3) == 0), 1'($urandom), 8'($urandom), 8'($urandom),
                     3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     $urandom_range(3), 1'($urandom));
    end

    $display("[TB] reset during EXEC");
    apply_stimulus(1, 0, 8'h00, 8'h5A, 3'd0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ld = 1'b0; cmd_a_sel = 1'b1; cmd_a = 8'hFF; cmd_b = 8'hFF;
    cmd_cin = 1'b1; cmd_wb = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    #1;
    m_acc = ACC_RST; m_carry = 1'b0; m_zero = (ACC_RST == 8'd0);
    check_output("mid_rst_res_valid", {8'd0, res_valid}, 9'd0);
    check_output("mid_rst_cmd_ready", {8'd0, cmd_ready}, 9'd0);
    check_state("mid_rst");
    repeat (2) begin
      @(posedge clk); #1;
      check_output("mid_rst_no_result", {8'd0, res_valid}, 9'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_output("after_rst_res_valid", {8'd0, res_valid}, 9'd0);
    check_state("after_rst");
    apply_stimulus(0, 0, 8'h00, 8'h07, 3'd5, 0, 1, 0, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
